// File: rtl/program_loader.sv
// program_loader
//
// Boot front-end for the single-cycle RISC-V core. It parses a little-endian
// byte stream (BASE, COUNT, COUNT data words, plus an optional checksum byte),
// writes each assembled word into instruction memory, and holds the core in
// reset until the image is complete. It then releases the core with BASE as
// its start address.
//
// Optional feature: define LOADER_CHECKSUM_EN to add the CHK state. A trailing
// byte must then equal the XOR of every header and data byte.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_data/in_valid    byte stream input
//   in_ready            loader can accept a byte (HDR_*, DATA, CHK)
//   reload              pulse in DONE/ERROR restarts loading
//   imem_we/addr/wdata  one-cycle instruction memory write
//   core_reset          core reset, low only in DONE
//   initial_address     BASE of the most recent header
//   done / error        load complete / load aborted
//   words_loaded        words written during the current load
module program_loader #(
    parameter int IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic [31:0] initial_address,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    typedef enum logic [2:0] {
        HDR_BASE,
        HDR_COUNT,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic [31:0] field;
    logic [31:0] addr_ptr;
    logic [31:0] words_left;
    logic        accept;
    logic        word_end;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_xor;
`endif

    assign accept   = in_valid & in_ready;
    assign word_end = accept && (byte_cnt == 2'd3);

    // Bytes shift in at the top. After four bytes, byte k sits in bits
    // [8k+7:8k]. field is the completed word in the cycle of its 4th byte.
    assign field = {in_data, word_buf[31:8]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_BASE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. reload is honoured only in DONE and ERROR.
    // The alignment check uses initial_address, which holds BASE once the
    // BASE field completes.
    always_comb begin
        state_next = state;
        case (state)
            HDR_BASE: begin
                if (word_end) begin
                    state_next = HDR_COUNT;
                end
            end
            HDR_COUNT: begin
                if (word_end) begin
                    if ((initial_address[1:0] != 2'b00) || (field > IMEM_LIMIT)) begin
                        state_next = ERROR;
                    end else if (field != 32'd0) begin
                        state_next = DATA;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
            DATA: begin
                if (word_end && (words_left == 32'd1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_next = (in_data == chk_xor) ? DONE : ERROR;
                end
            end
`endif
            DONE: begin
                if (reload) begin
                    state_next = HDR_BASE;
                end
            end
            ERROR: begin
                if (reload) begin
                    state_next = HDR_BASE;
                end
            end
            default: state_next = HDR_BASE;
        endcase
    end

    // Status outputs are decoded straight from the state. The core is
    // therefore released in the same cycle that the final write strobe is
    // visible.
    always_comb begin
        in_ready   = 1'b1;
        core_reset = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            DONE: begin
                in_ready   = 1'b0;
                core_reset = 1'b0;
                done       = 1'b1;
            end
            ERROR: begin
                in_ready = 1'b0;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: byte position, word assembly, header capture and write
    // strobe generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt        <= 2'd0;
            word_buf        <= 32'd0;
            addr_ptr        <= 32'd0;
            words_left      <= 32'd0;
            imem_we         <= 1'b0;
            imem_addr       <= 32'd0;
            imem_wdata      <= 32'd0;
            initial_address <= 32'd0;
            words_loaded    <= 16'd0;
        end else begin
            imem_we <= 1'b0;

            // The counter restarts on every state change, so a new field
            // always begins at byte 0.
            if (state_next != state) begin
                byte_cnt <= 2'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (accept) begin
                word_buf <= field;
            end

            case (state)
                HDR_BASE: begin
                    if (word_end) begin
                        initial_address <= field;
                        addr_ptr        <= field;
                    end
                end
                HDR_COUNT: begin
                    if (word_end) begin
                        words_left <= field;
                    end
                end
                DATA: begin
                    if (word_end) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= addr_ptr;
                        imem_wdata   <= field;
                        addr_ptr     <= addr_ptr + 32'd4;
                        words_left   <= words_left - 32'd1;
                        words_loaded <= words_loaded + 16'd1;
                    end
                end
                DONE, ERROR: begin
                    if (reload) begin
                        words_loaded <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over header and data bytes. It is cleared whenever the
    // parser re-enters HDR_BASE.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_xor <= 8'd0;
        end else if ((state_next == HDR_BASE) && (state != HDR_BASE)) begin
            chk_xor <= 8'd0;
        end else if (accept && (state != CHK)) begin
            chk_xor <= chk_xor ^ in_data;
        end
    end
`endif

endmodule
